// File: rtl/conv_result_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// conv_result_writeback_ctrl
//
// Write-back sequencer between the conv unit array and the feature map RAM
// banks. The block waits until every conv unit reports a finished slice. It then
// captures all kernel result buffers in one cycle and acknowledges the capture,
// so the conv units can start the next slice. Finally it writes the captured
// kernels out one at a time on the shared PARA_X-bank write port.
//
// Kernel k goes to address base_addr + k*kernel_stride on every bank. The sum
// wraps modulo 2^WRITE_ADDR_WIDTH. Bank x receives words [x*PY .. x*PY+PY-1]
// of kernel k. After each strobe the block waits until all banks report
// completion before it issues the next strobe.
//
// Optional feature (compile-time macro):
//   WB_RELU_EN  when defined, a slice captured with last_channel=1 has every
//               word with its sign bit set replaced by zero. This is a ReLU at
//               the point where the output channel is complete. When the macro
//               is undefined, data is written bit-exact.
//
// Ports:
//   clk              in   clock
//   rst              in   asynchronous active-low reset
//   result_ready     in   [PARA_KERNEL]      per-kernel result ready
//   result_buffer    in   [PK*PX*PY*DW]      kernel k at [k*PX*PY*DW +: PX*PY*DW]
//   base_addr        in   [WRITE_ADDR_WIDTH] write address of kernel 0
//   kernel_stride    in   [WRITE_ADDR_WIDTH] address step between kernels
//   accumulate       in   1 = add-write (partial sum), 0 = overwrite
//   last_channel     in   1 = slice completes the output channel
//   fm_write_ready   in   [PARA_X]           per-bank write complete
//   capture_ack      out  one-cycle pulse: buffers captured
//   fm_ena_wr        out  one-cycle write strobe to all banks
//   fm_ena_add_write out  add-write select, valid with fm_ena_wr
//   fm_addr_write    out  [PX*WRITE_ADDR_WIDTH] per-bank write address
//   fm_din           out  [PX*PY*DW]         bank x at [x*PY*DW +: PY*DW]
//   busy             out  high from capture until the last write completes
//   done             out  one-cycle pulse after the last kernel is written
// -----------------------------------------------------------------------------
module conv_result_writeback_ctrl #(
    parameter int DATA_WIDTH       = 16,
    parameter int PARA_KERNEL      = 2,
    parameter int PARA_X           = 3,
    parameter int PARA_Y           = 3,
    parameter int WRITE_ADDR_WIDTH = 3
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [PARA_KERNEL-1:0]                           result_ready,
    input  logic [PARA_KERNEL*PARA_X*PARA_Y*DATA_WIDTH-1:0]  result_buffer,
    input  logic [WRITE_ADDR_WIDTH-1:0]                      base_addr,
    input  logic [WRITE_ADDR_WIDTH-1:0]                      kernel_stride,
    input  logic                                             accumulate,
    input  logic                                             last_channel,
    input  logic [PARA_X-1:0]                                fm_write_ready,
    output logic                                             capture_ack,
    output logic                                             fm_ena_wr,
    output logic                                             fm_ena_add_write,
    output logic [PARA_X*WRITE_ADDR_WIDTH-1:0]               fm_addr_write,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]              fm_din,
    output logic                                             busy,
    output logic                                             done
);

    localparam int KERNEL_WORDS = PARA_X * PARA_Y;
    localparam int KERNEL_BITS  = KERNEL_WORDS * DATA_WIDTH;
    localparam int BUF_BITS     = PARA_KERNEL * KERNEL_BITS;
    localparam int KW           = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;
    localparam int AW           = WRITE_ADDR_WIDTH;

    localparam logic [KW-1:0] K_LAST = KW'(PARA_KERNEL - 1);

`ifdef WB_RELU_EN
    localparam logic RELU_ON = 1'b1;
`else
    localparam logic RELU_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Zero every word whose sign bit is set. This covers -0, negative values
    // and negative NaN alike. When en=0 the words pass through untouched.
    function automatic logic [KERNEL_BITS-1:0] relu_clamp(
        input logic [KERNEL_BITS-1:0] words,
        input logic                   en
    );
        logic [KERNEL_BITS-1:0] res;
        res = words;
        for (int i = 0; i < KERNEL_WORDS; i++) begin
            if (en && words[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
                res[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else begin
                res[i*DATA_WIDTH +: DATA_WIDTH] = words[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [KW-1:0]           k_r;
    logic [KW-1:0]           k_nxt_s;
    logic [AW-1:0]           addr_r;
    logic [AW-1:0]           addr_nxt_s;

    logic [BUF_BITS-1:0]     buf_r;
    logic [AW-1:0]           base_r;
    logic [AW-1:0]           stride_r;
    logic                    acc_r;
    logic                    last_r;

    logic                    capture_s;
    logic                    banks_done_s;
    logic [KERNEL_BITS-1:0]  kernel_sel_s;
    logic [KERNEL_BITS-1:0]  din_nxt_s;

    logic                    capture_ack_nxt_s;
    logic                    fm_ena_wr_nxt_s;
    logic                    fm_ena_add_write_nxt_s;
    logic [PARA_X*AW-1:0]    fm_addr_write_nxt_s;
    logic [KERNEL_BITS-1:0]  fm_din_nxt_s;
    logic                    busy_nxt_s;
    logic                    done_nxt_s;

    // Capture only when every kernel is ready. Partial readiness is ignored.
    assign capture_s    = (state_r == ST_IDLE) && (&result_ready);
    // A kernel write is complete only when all banks report it at the same time.
    assign banks_done_s = &fm_write_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: state_nxt_s = ST_WRITE;
            ST_WRITE:   state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (banks_done_s) begin
                    state_nxt_s = (k_r == K_LAST) ? ST_DONE : ST_WRITE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Kernel index and running write address. The address is advanced by
    // addition, so it wraps naturally at 2^AW.
    always_comb begin
        k_nxt_s    = k_r;
        addr_nxt_s = addr_r;
        case (state_r)
            ST_CAPTURE: begin
                k_nxt_s    = {KW{1'b0}};
                addr_nxt_s = base_r;
            end
            ST_WAIT: begin
                if (banks_done_s && (k_r != K_LAST)) begin
                    k_nxt_s    = k_r + KW'(1);
                    addr_nxt_s = addr_r + stride_r;
                end else begin
                    k_nxt_s    = k_r;
                    addr_nxt_s = addr_r;
                end
            end
            default: begin
                k_nxt_s    = k_r;
                addr_nxt_s = addr_r;
            end
        endcase
    end

    // Kernel index and address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_r    <= {KW{1'b0}};
            addr_r <= {AW{1'b0}};
        end else begin
            k_r    <= k_nxt_s;
            addr_r <= addr_nxt_s;
        end
    end

    // Capture registers. These are loaded once per slice; after the
    // acknowledge, upstream is free to change its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_r    <= {BUF_BITS{1'b0}};
            base_r   <= {AW{1'b0}};
            stride_r <= {AW{1'b0}};
            acc_r    <= 1'b0;
            last_r   <= 1'b0;
        end else if (capture_s) begin
            buf_r    <= result_buffer;
            base_r   <= base_addr;
            stride_r <= kernel_stride;
            acc_r    <= accumulate;
            last_r   <= last_channel;
        end
    end

    // Select the kernel about to be written. The ReLU clamp is a pure function
    // of the captured words and the captured last_channel flag.
    always_comb begin
        kernel_sel_s = {KERNEL_BITS{1'b0}};
        for (int i = 0; i < PARA_KERNEL; i++) begin
            kernel_sel_s = (k_nxt_s == KW'(i)) ? buf_r[i*KERNEL_BITS +: KERNEL_BITS]
                                               : kernel_sel_s;
        end
        din_nxt_s = relu_clamp(kernel_sel_s, RELU_ON & last_r);
    end

    // Output decode from the next state. The outputs are registered, so they
    // line up with the state they describe. The address and data buses keep
    // their last value outside the write strobe.
    always_comb begin
        capture_ack_nxt_s      = 1'b0;
        fm_ena_wr_nxt_s        = 1'b0;
        fm_ena_add_write_nxt_s = 1'b0;
        fm_addr_write_nxt_s    = fm_addr_write;
        fm_din_nxt_s           = fm_din;
        busy_nxt_s             = 1'b0;
        done_nxt_s             = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_CAPTURE: begin
                capture_ack_nxt_s = 1'b1;
                busy_nxt_s        = 1'b1;
            end
            ST_WRITE: begin
                fm_ena_wr_nxt_s        = 1'b1;
                fm_ena_add_write_nxt_s = acc_r;
                fm_addr_write_nxt_s    = {PARA_X{addr_nxt_s}};
                fm_din_nxt_s           = din_nxt_s;
                busy_nxt_s             = 1'b1;
            end
            ST_WAIT: begin
                busy_nxt_s = 1'b1;
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers. Reset aborts a write at once and gives no done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capture_ack      <= 1'b0;
            fm_ena_wr        <= 1'b0;
            fm_ena_add_write <= 1'b0;
            fm_addr_write    <= {(PARA_X*AW){1'b0}};
            fm_din           <= {KERNEL_BITS{1'b0}};
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            capture_ack      <= capture_ack_nxt_s;
            fm_ena_wr        <= fm_ena_wr_nxt_s;
            fm_ena_add_write <= fm_ena_add_write_nxt_s;
            fm_addr_write    <= fm_addr_write_nxt_s;
            fm_din           <= fm_din_nxt_s;
            busy             <= busy_nxt_s;
            done             <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_conv_result_writeback_ctrl.sv
module tb_conv_result_writeback_ctrl;

    localparam int DW = 16;
    localparam int PK = 2;
    localparam int PX = 3;
    localparam int PY = 3;
    localparam int AW = 3;
    localparam int KB = PX * PY * DW;

`ifdef WB_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [PK-1:0]        result_ready = '0;
    logic [PK*KB-1:0]     result_buffer = '0;
    logic [AW-1:0]        base_addr = '0;
    logic [AW-1:0]        kernel_stride = '0;
    logic                 accumulate = 1'b0;
    logic                 last_channel = 1'b0;
    logic [PX-1:0]        fm_write_ready;
    logic                 capture_ack;
    logic                 fm_ena_wr;
    logic                 fm_ena_add_write;
    logic [PX*AW-1:0]     fm_addr_write;
    logic [KB-1:0]        fm_din;
    logic                 busy;
    logic                 done;

    conv_result_writeback_ctrl #(
        .DATA_WIDTH(DW), .PARA_KERNEL(PK), .PARA_X(PX), .PARA_Y(PY), .WRITE_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .result_ready(result_ready), .result_buffer(result_buffer),
        .base_addr(base_addr), .kernel_stride(kernel_stride), .accumulate(accumulate),
        .last_channel(last_channel), .fm_write_ready(fm_write_ready),
        .capture_ack(capture_ack), .fm_ena_wr(fm_ena_wr), .fm_ena_add_write(fm_ena_add_write),
        .fm_addr_write(fm_addr_write), .fm_din(fm_din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          add;
        logic [KB-1:0] din;
        int            exp_cycle;   // absolute strobe cycle, or -1 to check gap
        int            gap;         // cycles since previous strobe
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          pending_done = 0;
    int          acks = 0;
    int          exp_acks = 0;
    int          ram_delay[PX];
    int          ram_cnt[PX];
    logic [DW-1:0] buf_words[PK][PX][PY];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [KB-1:0] act, input logic [KB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bank model: on a strobe each bank drops ready. It raises ready again
    // ram_delay cycles later and holds it until the next strobe.
    initial begin
        fm_write_ready = '1;
        for (int x = 0; x < PX; x++) begin
            ram_cnt[x] = 0;
            ram_delay[x] = 1;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int x = 0; x < PX; x++) begin
                if (fm_ena_wr) begin
                    fm_write_ready[x] = 1'b0;
                    ram_cnt[x] = ram_delay[x];
                end else if (ram_cnt[x] > 0) begin
                    ram_cnt[x] = ram_cnt[x] - 1;
                    if (ram_cnt[x] == 0) fm_write_ready[x] = 1'b1;
                end
            end
        end
    end

    // Monitor: pop the scoreboard on every strobe and done pulse.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            if (fm_ena_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got strobe addr %h expected none", fm_addr_write);
                end else begin
                    e = exp_q.pop_front();
                    for (int x = 0; x < PX; x++)
                        chk($sformatf("addr_bank%0d", x), KB'(fm_addr_write[x*AW +: AW]), KB'(e.addr));
                    chk("add_write", KB'(fm_ena_add_write), KB'(e.add));
                    chk("din", fm_din, e.din);
                    if (e.exp_cycle >= 0) chk("first_strobe_cycle", KB'(cyc), KB'(e.exp_cycle));
                    else                  chk("strobe_gap", KB'(cyc - last_wr_cyc), KB'(e.gap));
                end
                last_wr_cyc = cyc;
            end
            if (done) begin
                if (pending_done == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    pending_done--;
                end
                chk("busy_at_done", KB'(busy), KB'(0));
            end
            if (capture_ack) acks++;
        end
    end

    task automatic fill_buf(input logic [DW-1:0] seed);
        for (int k = 0; k < PK; k++)
            for (int x = 0; x < PX; x++)
                for (int y = 0; y < PY; y++)
                    buf_words[k][x][y] = seed + DW'(k*16'h0400 + x*16'h0030 + y*16'h0003)
                                         ^ (((x + y) % 2 == 1) ? 16'h8000 : 16'h0000);
    endtask

    task automatic push_kernel(input int k, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input logic acc, input logic last, input int first_cyc, input int gap);
        wr_t e;
        logic [DW-1:0] w;
        e.addr = AW'(int'(base) + k * int'(stride));
        e.add = acc;
        e.din = '0;
        for (int x = 0; x < PX; x++)
            for (int y = 0; y < PY; y++) begin
                w = buf_words[k][x][y];
                if (RELU && last && w[DW-1]) w = 16'h0000;
                e.din[(x*PY + y)*DW +: DW] = w;
            end
        e.exp_cycle = (k == 0) ? first_cyc : -1;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic drive_inputs(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                input logic acc, input logic last);
        for (int k = 0; k < PK; k++)
            for (int x = 0; x < PX; x++)
                for (int y = 0; y < PY; y++)
                    result_buffer[k*KB + (x*PY + y)*DW +: DW] = buf_words[k][x][y];
        base_addr = base;
        kernel_stride = stride;
        accumulate = acc;
        last_channel = last;
    endtask

    task automatic wait_ack(input string tag);
        int t = 0;
        do begin @(negedge clk); t++; end while (!capture_ack && t < 10);
        if (!capture_ack) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: got no ack expected ack", tag);
        end
    endtask

    task automatic run_slice(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic acc, input logic last, input int d0, input int d1, input int d2);
        int n;
        int t;
        int dmax;
        ram_delay[0] = d0;
        ram_delay[1] = d1;
        ram_delay[2] = d2;
        dmax = (d0 > d1) ? d0 : d1;
        dmax = (d2 > dmax) ? d2 : dmax;
        @(posedge clk);
        #1;
        drive_inputs(base, stride, acc, last);
        result_ready = '1;
        n = cyc;
        for (int k = 0; k < PK; k++) push_kernel(k, base, stride, acc, last, n + 2, dmax + 1);
        pending_done++;
        exp_acks++;
        wait_ack(tag);
        // Inputs change after the ack and must have no effect.
        @(posedge clk);
        #1;
        result_ready = '0;
        result_buffer = '1;
        base_addr = ~base;
        kernel_stride = ~stride;
        accumulate = ~acc;
        last_channel = ~last;
        t = 0;
        while (!done && t < 300) begin @(negedge clk); t++; end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done", tag);
        end
        @(posedge clk);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, KB'({capture_ack, fm_ena_wr, fm_ena_add_write, busy, done,
                       |fm_addr_write, |fm_din}), KB'(0));
    endtask

    initial begin
        int acks_before;
        int t;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset_state");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("idle_after_reset");

        // Basic two-kernel write: addresses 1 then 3.
        fill_buf(16'h0101);
        run_slice("basic", 3'd1, 3'd2, 1'b0, 1'b0, 1, 1, 1);

        // Address wrap: 7, then (7+3) mod 8 = 2.
        fill_buf(16'h0222);
        run_slice("wrap", 3'd7, 3'd3, 1'b0, 1'b0, 1, 1, 1);

        // Add-write with slow, unequal banks. The next strobe must wait for the slowest bank.
        fill_buf(16'h0345);
        run_slice("slow_acc", 3'd2, 3'd1, 1'b1, 1'b0, 4, 2, 3);

        // Partial readiness is ignored.
        fill_buf(16'h0456);
        drive_inputs(3'd0, 3'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1 result_ready = 2'b01;
        acks_before = acks;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("partial_no_ack", KB'(acks), KB'(acks_before));
        chk("partial_not_busy", KB'(busy), KB'(0));
        run_slice("after_partial", 3'd0, 3'd1, 1'b0, 1'b0, 1, 1, 1);

        // Sign-bit words with last_channel set, then the same words with last_channel clear.
        fill_buf(16'h0011);
        buf_words[0][0][0] = 16'hBC00;
        buf_words[0][0][1] = 16'h3C00;
        buf_words[1][2][2] = 16'h8000;
        buf_words[1][1][0] = 16'hFE00;
        run_slice("relu_last", 3'd4, 3'd1, 1'b0, 1'b1, 1, 1, 1);
        run_slice("relu_notlast", 3'd4, 3'd1, 1'b0, 1'b0, 2, 1, 1);

        // Zero stride: both kernels go to the same address.
        fill_buf(16'h0567);
        run_slice("stride0", 3'd5, 3'd0, 1'b1, 1'b0, 1, 2, 1);

        // Reset while waiting on kernel 0: no second write and no done pulse.
        fill_buf(16'h0678);
        ram_delay[0] = 60;
        ram_delay[1] = 60;
        ram_delay[2] = 60;
        @(posedge clk);
        #1;
        drive_inputs(3'd2, 3'd1, 1'b1, 1'b0);
        result_ready = '1;
        push_kernel(0, 3'd2, 3'd1, 1'b1, 1'b0, cyc + 2, 0);
        exp_acks++;
        wait_ack("rst_mid");
        t = 0;
        while (!fm_ena_wr && t < 10) begin @(negedge clk); t++; end
        if (!fm_ena_wr) begin
            checks++;
            errors++;
            $display("FAIL rst_mid_strobe_timeout: got no strobe expected strobe");
        end
        @(posedge clk);
        #1 result_ready = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_idle_outputs("rst_mid_immediate");
        repeat (2) @(negedge clk);
        chk_idle_outputs("rst_mid_held");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_mid_released");

        fill_buf(16'h0789);
        run_slice("after_rst", 3'd6, 3'd1, 1'b0, 1'b0, 1, 1, 1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("writes_outstanding", KB'(exp_q.size()), KB'(0));
        chk("dones_outstanding", KB'(pending_done), KB'(0));
        chk("ack_count", KB'(acks), KB'(exp_acks));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
